// File: rtl/alu_issue_ctrl_if.sv
// Instruction, ALU-bus and debug-read signals of the ALU issue controller.
//   master : instruction source / ALU responder / debug reader (drives in_*, alu_result, rd_addr)
//   slave  : the issue controller (drives in_ready, alu_*, done, err, rd_data)
interface alu_issue_ctrl_if #(
    parameter int unsigned N  = 32,
    parameter int unsigned AW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_dst;
    logic [AW-1:0] in_src_a;
    logic [AW-1:0] in_src_b;
    logic [N-1:0]  in_imm;
    logic [2:0]    alu_op;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [N-1:0]  alu_result;
    logic          done;
    logic          err;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;

    modport master (
        output in_valid, in_op, in_dst, in_src_a, in_src_b, in_imm, alu_result, rd_addr,
        input  in_ready, alu_op, alu_a, alu_b, done, err, rd_data
    );

    modport slave (
        input  in_valid, in_op, in_dst, in_src_a, in_src_b, in_imm, alu_result, rd_addr,
        output in_ready, alu_op, alu_a, alu_b, done, err, rd_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one instruction at a time, reads operands from a small
// register file, drives a registered ALU, waits its fixed latency and writes the result back.
// LDI and illegal opcodes retire locally in one cycle.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   bus_io : instruction handshake, ALU op/operand/result bus, done/err pulses, debug read port
module alu_issue_ctrl #(
    parameter int unsigned N    = 32,
    parameter int unsigned NREG = 4,
    parameter int unsigned AW   = 2,
    parameter int unsigned LAT  = 2
) (
    input logic             clk,
    input logic             rst,
    alu_issue_ctrl_if.slave bus_io
);
    localparam int unsigned CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

    localparam logic [2:0] OpLdi = 3'b110;
    localparam logic [2:0] OpIll = 3'b111;

    typedef enum logic {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [N-1:0]    rf_q [NREG];

    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [N-1:0]    rf_wdata;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        dst_d    = dst_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = dst_q;
        rf_wdata = bus_io.alu_result;

        unique case (state_q)
            StIdle: begin
                if (bus_io.in_valid) begin
                    case (bus_io.in_op)
                        OpLdi: begin
                            rf_we    = 1'b1;
                            rf_waddr = bus_io.in_dst;
                            rf_wdata = bus_io.in_imm;
                            done_d   = 1'b1;
                        end
                        OpIll: begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end
                        default: begin
                            // Operands are read here, so src == dst sees the old value.
                            op_d    = bus_io.in_op;
                            a_d     = rf_q[bus_io.in_src_a];
                            b_d     = rf_q[bus_io.in_src_b];
                            dst_d   = bus_io.in_dst;
                            cnt_d   = '0;
                            state_d = StWait;
                        end
                    endcase
                end
            end
            StWait: begin
                // The ALU result register is valid once the counter reaches LAT.
                if (cnt_q == CW'(LAT)) begin
                    rf_we   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dst_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dst_q   <= dst_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign bus_io.in_ready = (state_q == StIdle);
    assign bus_io.alu_op   = op_q;
    assign bus_io.alu_a    = a_q;
    assign bus_io.alu_b    = b_q;
    assign bus_io.done     = done_q;
    assign bus_io.err      = err_q;
    assign bus_io.rd_data  = rf_q[bus_io.rd_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a two-stage registered ALU model responds on the ALU bus, and a
// behavioural register-file model predicts every architectural result.
module tb_alu_issue_ctrl;
    localparam int unsigned N   = 32;
    localparam int unsigned AW  = 2;
    localparam int unsigned LAT = 2;

    typedef struct packed {
        logic [2:0]    op;
        logic [AW-1:0] dst;
        logic [AW-1:0] sa;
        logic [AW-1:0] sb;
        logic [N-1:0]  imm;
        logic [N-1:0]  want;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [N-1:0] alu_s1;
    logic [N-1:0] m_rf [4];

    alu_issue_ctrl_if #(.N(N), .AW(AW)) bus ();

    alu_issue_ctrl #(.N(N), .NREG(4), .AW(AW), .LAT(LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] alu_ref(input logic [2:0] op, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        case (op)
            3'd0:    return a;
            3'd1:    return ~a;
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return a | b;
            3'd5:    return a & b;
            default: return '0;
        endcase
    endfunction

    // Registered ALU: samples on the first edge, result register updates on the LAT-th edge.
    always @(posedge clk) begin
        alu_s1         <= alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
        bus.alu_result <= alu_s1;
    end

    task automatic m_exec(input logic [2:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] sa,
                          input logic [AW-1:0] sb, input logic [N-1:0] imm);
        if (op == 3'd6) m_rf[dst] = imm;
        else if (op != 3'd7) m_rf[dst] = alu_ref(op, m_rf[sa], m_rf[sb]);
    endtask

    // Presents one instruction and returns 1 ns after its transfer edge.
    task automatic send(input logic [2:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] sa,
                        input logic [AW-1:0] sb, input logic [N-1:0] imm, output bit ok);
        bus.in_op    = op;
        bus.in_dst   = dst;
        bus.in_src_a = sa;
        bus.in_src_b = sb;
        bus.in_imm   = imm;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int r = 0; r < 4; r++) m_rf[r] = '0;
        checks++;
        if ({bus.in_ready, bus.done, bus.err, bus.alu_op, bus.alu_a, bus.alu_b} !==
            {1'b1, 1'b0, 1'b0, 3'd0, {N{1'b0}}, {N{1'b0}}}) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b done=%b err=%b op=%0d a=%h b=%h want 1 0 0 0 0 0",
                     bus.in_ready, bus.done, bus.err, bus.alu_op, bus.alu_a, bus.alu_b);
        end
        for (int r = 0; r < 4; r++) begin
            bus.rd_addr = AW'(r); #1;
            checks++;
            if (bus.rd_data !== '0) begin
                failures++;
                $display("FAIL reset_rf%0d: got %h want 0", r, bus.rd_data);
            end
        end
    endtask

    task automatic test_ldi();
        bit ok;
        send(3'd6, 2'd1, 2'd0, 2'd0, 32'h5, ok);
        m_exec(3'd6, 2'd1, 2'd0, 2'd0, 32'h5);
        checks++;
        if (!ok || bus.done !== 1'b1 || bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ldi1_pulse: got ok=%b done=%b err=%b rdy=%b want 1 1 0 1",
                     ok, bus.done, bus.err, bus.in_ready);
        end
        send(3'd6, 2'd2, 2'd0, 2'd0, 32'h3, ok);
        m_exec(3'd6, 2'd2, 2'd0, 2'd0, 32'h3);
        checks++;
        if (!ok || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL ldi2_pulse: got ok=%b done=%b want 1 1", ok, bus.done);
        end
        bus.rd_addr = 2'd1; #1;
        checks++;
        if (bus.rd_data !== 32'h5) begin
            failures++;
            $display("FAIL ldi_r1: got %h want 00000005", bus.rd_data);
        end
        bus.rd_addr = 2'd2; #1;
        checks++;
        if (bus.rd_data !== 32'h3) begin
            failures++;
            $display("FAIL ldi_r2: got %h want 00000003", bus.rd_data);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL ldi_done_drop: got %b want 0", bus.done);
        end
    endtask

    task automatic test_alu_ops();
        instr_t       tbl [11];
        bit           ok;
        logic [N-1:0] ea, eb, old;
        tbl[0]  = '{3'd2, 2'd3, 2'd1, 2'd2, 32'h0, 32'h0000_0008};
        tbl[1]  = '{3'd3, 2'd0, 2'd2, 2'd1, 32'h0, 32'hFFFF_FFFE};
        tbl[2]  = '{3'd6, 2'd1, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[3]  = '{3'd2, 2'd1, 2'd1, 2'd1, 32'h0, 32'hFFFF_FFFE};
        tbl[4]  = '{3'd6, 2'd2, 2'd0, 2'd0, 32'h0000_00F0, 32'h0000_00F0};
        tbl[5]  = '{3'd1, 2'd2, 2'd2, 2'd0, 32'h0, 32'hFFFF_FF0F};
        tbl[6]  = '{3'd6, 2'd0, 2'd0, 2'd0, 32'hF0F0_0000, 32'hF0F0_0000};
        tbl[7]  = '{3'd6, 2'd3, 2'd0, 2'd0, 32'h0FF0_0000, 32'h0FF0_0000};
        tbl[8]  = '{3'd4, 2'd1, 2'd0, 2'd3, 32'h0, 32'hFFF0_0000};
        tbl[9]  = '{3'd5, 2'd2, 2'd0, 2'd3, 32'h0, 32'h00F0_0000};
        tbl[10] = '{3'd0, 2'd3, 2'd2, 2'd1, 32'h0, 32'h00F0_0000};
        foreach (tbl[k]) begin
            ea  = m_rf[tbl[k].sa];
            eb  = m_rf[tbl[k].sb];
            old = m_rf[tbl[k].dst];
            send(tbl[k].op, tbl[k].dst, tbl[k].sa, tbl[k].sb, tbl[k].imm, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL op%0d_accept: got no transfer want transfer", k);
            end
            if (tbl[k].op != 3'd6) begin
                for (int c = 0; c <= int'(LAT); c++) begin
                    checks++;
                    if ({bus.in_ready, bus.done, bus.alu_op, bus.alu_a, bus.alu_b} !==
                        {1'b0, 1'b0, tbl[k].op, ea, eb}) begin
                        failures++;
                        $display("FAIL op%0d_wait%0d: got rdy=%b done=%b op=%0d a=%h b=%h want 0 0 %0d %h %h",
                                 k, c, bus.in_ready, bus.done, bus.alu_op, bus.alu_a, bus.alu_b,
                                 tbl[k].op, ea, eb);
                    end
                    if (c == int'(LAT)) begin
                        bus.rd_addr = tbl[k].dst; #1;
                        checks++;
                        if (bus.rd_data !== old) begin
                            failures++;
                            $display("FAIL op%0d_prewrite: got %h want %h", k, bus.rd_data, old);
                        end
                    end
                    @(posedge clk); #1;
                end
            end
            checks++;
            if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL op%0d_retire: got done=%b err=%b rdy=%b want 1 0 1",
                         k, bus.done, bus.err, bus.in_ready);
            end
            bus.rd_addr = tbl[k].dst; #1;
            checks++;
            if (bus.rd_data !== tbl[k].want) begin
                failures++;
                $display("FAIL op%0d_result: got %h want %h", k, bus.rd_data, tbl[k].want);
            end
            m_exec(tbl[k].op, tbl[k].dst, tbl[k].sa, tbl[k].sb, tbl[k].imm);
        end
    endtask

    task automatic test_back_to_back();
        int            t_acc [3];
        logic [2:0]    ops [3];
        logic [AW-1:0] dsts [3];
        int            w;
        ops[0] = 3'd2; dsts[0] = 2'd0;
        ops[1] = 3'd3; dsts[1] = 2'd1;
        ops[2] = 3'd4; dsts[2] = 2'd2;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_op    = ops[k];
            bus.in_dst   = dsts[k];
            bus.in_src_a = AW'(k + 1);
            bus.in_src_b = AW'(3 - k);
            w = 0;
            while (bus.in_ready !== 1'b1 && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready%0d: got %b want 1", k, bus.in_ready);
            end
            @(posedge clk); #1;
            t_acc[k] = cyc;
            m_exec(ops[k], dsts[k], AW'(k + 1), AW'(3 - k), '0);
        end
        bus.in_valid = 1'b0;
        w = 0;
        while (bus.done !== 1'b1 && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (w != int'(LAT) + 1) begin
            failures++;
            $display("FAIL b2b_last_done: got %0d cycles want %0d", w, LAT + 1);
        end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (t_acc[k] - t_acc[k-1] != int'(LAT) + 2) begin
                failures++;
                $display("FAIL b2b_spacing%0d: got %0d want %0d", k, t_acc[k] - t_acc[k-1], LAT + 2);
            end
        end
        for (int r = 0; r < 4; r++) begin
            bus.rd_addr = AW'(r); #1;
            checks++;
            if (bus.rd_data !== m_rf[r]) begin
                failures++;
                $display("FAIL b2b_rf%0d: got %h want %h", r, bus.rd_data, m_rf[r]);
            end
        end
    endtask

    task automatic test_illegal();
        bit ok;
        send(3'd7, 2'd3, 2'd1, 2'd2, 32'hDEAD_BEEF, ok);
        checks++;
        if (!ok || bus.done !== 1'b1 || bus.err !== 1'b1 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL illegal_pulse: got ok=%b done=%b err=%b rdy=%b want 1 1 1 1",
                     ok, bus.done, bus.err, bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL illegal_drop: got done=%b err=%b want 0 0", bus.done, bus.err);
        end
        for (int r = 0; r < 4; r++) begin
            bus.rd_addr = AW'(r); #1;
            checks++;
            if (bus.rd_data !== m_rf[r]) begin
                failures++;
                $display("FAIL illegal_rf%0d: got %h want %h", r, bus.rd_data, m_rf[r]);
            end
        end
    endtask

    task automatic test_random();
        bit            ok;
        logic [2:0]    op;
        logic [AW-1:0] dst, sa, sb;
        logic [N-1:0]  imm;
        int            n, exp_n;
        for (int it = 0; it < 30; it++) begin
            op  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) op = 3'd6;
            dst = AW'($urandom_range(0, 3));
            sa  = AW'($urandom_range(0, 3));
            sb  = AW'($urandom_range(0, 3));
            imm = $urandom;
            exp_n = (op < 3'd6) ? int'(LAT) + 1 : 0;
            m_exec(op, dst, sa, sb, imm);
            send(op, dst, sa, sb, imm, ok);
            n = 0;
            while (bus.done !== 1'b1 && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (!ok || n != exp_n || bus.err !== (op == 3'd7)) begin
                failures++;
                $display("FAIL rand%0d_timing: op=%0d got ok=%b lat=%0d err=%b want 1 %0d %b",
                         it, op, ok, n, bus.err, exp_n, op == 3'd7);
            end
            for (int r = 0; r < 4; r++) begin
                bus.rd_addr = AW'(r); #1;
                checks++;
                if (bus.rd_data !== m_rf[r]) begin
                    failures++;
                    $display("FAIL rand%0d_rf%0d: got %h want %h", it, r, bus.rd_data, m_rf[r]);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d_pulse: got done=%b err=%b want 0 0", it, bus.done, bus.err);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        int seen;
        send(3'd6, 2'd1, 2'd0, 2'd0, 32'h7, ok);
        send(3'd6, 2'd2, 2'd0, 2'd0, 32'h9, ok);
        send(3'd2, 2'd3, 2'd1, 2'd2, 32'h0, ok);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int r = 0; r < 4; r++) m_rf[r] = '0;
        checks++;
        if ({bus.in_ready, bus.done, bus.err, bus.alu_op, bus.alu_a, bus.alu_b} !==
            {1'b1, 1'b0, 1'b0, 3'd0, {N{1'b0}}, {N{1'b0}}}) begin
            failures++;
            $display("FAIL midrst_outputs: got rdy=%b done=%b err=%b op=%0d a=%h b=%h want 1 0 0 0 0 0",
                     bus.in_ready, bus.done, bus.err, bus.alu_op, bus.alu_a, bus.alu_b);
        end
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.done === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midrst_no_done: got %0d pulses want 0", seen);
        end
        for (int r = 0; r < 4; r++) begin
            bus.rd_addr = AW'(r); #1;
            checks++;
            if (bus.rd_data !== m_rf[r]) begin
                failures++;
                $display("FAIL midrst_rf%0d: got %h want %h", r, bus.rd_data, m_rf[r]);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_dst   = '0;
        bus.in_src_a = '0;
        bus.in_src_b = '0;
        bus.in_imm   = '0;
        bus.rd_addr  = '0;
        @(posedge clk); #1;
        test_reset();
        test_ldi();
        test_alu_ops();
        test_back_to_back();
        test_illegal();
        test_random();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
